pattern_hit_window_counter: RTL and testbench
=============================================

# pattern_hit_window_counter

Downstream consumer of the serial pattern detector's two hit lines: `hit[1]` flags a completed "101" and `hit[0]` a completed "010". The block counts both hit types over fixed windows of WINDOW enabled clock cycles. At the end of each window it hands a count report to the next stage over a valid/ready handshake. If the consumer stalls, whole windows are dropped and a sticky flag records the loss.

## Interface
- CNT_W, 8, width of each hit counter and report field (≥2)
- WINDOW, 16, window length in enabled cycles (≥2)
- clock  in  1  single clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  counting enable; window timer and hit counters advance only when 1
- hit  in  2  detector outputs, sampled every enabled cycle; bit 1 = "101", bit 0 = "010"
- rpt_valid  out  1  report available
- rpt_ready  in  1  consumer accepts report when rpt_valid & rpt_ready at a rising edge
- rpt_cnt101  out  CNT_W  "101" count of reported window
- rpt_cnt010  out  CNT_W  "010" count of reported window
- dropped  out  1  sticky: at least one window was discarded
- clr_drop  in  1  synchronous clear of dropped

## Operation
- State:
  - window timer `wcnt`, 0..WINDOW-1;
  - live counters `c101` and `c010`;
  - report registers;
  - `rpt_valid`;
  - `dropped`.
- Enabled cycle (en=1):
  - `c101` += hit[1] and `c010` += hit[0], independently. Both bits may be high in the same cycle, and both are then counted.
  - Each counter saturates at 2^CNT_W-1 and never wraps.
  - If wcnt != WINDOW-1, wcnt increments.
- Close cycle (en=1 and wcnt == WINDOW-1):
  - Final counts include this cycle's hits, with saturation applied.
  - wcnt, c101 and c010 return to 0 at the edge.
  - If the report slot is free (rpt_valid=0) or is being accepted this cycle (rpt_valid & rpt_ready), the final counts load into rpt_cnt101/rpt_cnt010 and rpt_valid=1.
  - Otherwise the window is discarded, dropped<=1, and the held report is untouched.
- Disabled cycle (en=0):
  - wcnt, c101 and c010 hold, and hits are ignored.
  - The handshake still operates.
- Handshake:
  - rpt_valid stays 1 and the report fields stay stable until accepted.
  - On acceptance without a simultaneous close, rpt_valid<=0. The report fields may hold stale values.
  - rpt_ready while rpt_valid=0 has no effect.
- Drop flag:
  - clr_drop=1 clears dropped.
  - If clr_drop and a drop event occur in the same cycle, dropped=1 (set wins).
- Two-state control: IDLE (rpt_valid=0) and PENDING (rpt_valid=1).
  - IDLE→PENDING on close.
  - PENDING→IDLE on accept without close.
  - PENDING→PENDING on accept+close (new report) or on close without accept (drop).

## Timing
- Reset (reset_n=0, asynchronous) forces the following immediately, independent of clock:
  - rpt_valid=0;
  - rpt_cnt101=0;
  - rpt_cnt010=0;
  - dropped=0;
  - wcnt=0;
  - c101=0;
  - c010=0.
- All outputs are registered; there is no combinational path from any input to any output.
- Report latency: rpt_valid rises on the edge that ends the close cycle. With en held at 1, that is the WINDOW-th enabled edge after the window starts.
- Accept + close in the same cycle: rpt_valid stays 1 and the fields update to the new window with no bubble.
- Reset asserted mid-window discards the partial counts and any pending report. After release, the first enabled edge counts as window cycle 0.
- Throughput: one report per WINDOW enabled cycles when rpt_ready is held at 1.

## Test plan
- Reset mid-operation:
  - Stimulus: assert reset_n=0 at window cycle 7 with rpt_valid=1 and dropped=1.
  - Required: all outputs 0 immediately.
  - Required after release: the next report closes exactly 16 enabled cycles later.
- Basic count (WINDOW=16, en=1, rpt_ready=0):
  - Stimulus: hit=2'b10 on 3 cycles and hit=2'b01 on 5 cycles, including one hit on the close cycle.
  - Required after the 16th edge: rpt_valid=1, rpt_cnt101=3, rpt_cnt010=5, all held stable for 10 further cycles.
- Back-pressure:
  - Stimulus: rpt_ready=0 through two window closes.
  - Required: the first report is retained unchanged and dropped=1 after the second close.
  - Then: clr_drop=1 for one cycle gives dropped=0.
- Accept on close:
  - Stimulus: rpt_ready=1 only on the close cycle of window 2.
  - Required: rpt_valid remains 1, the fields switch to window 2 counts, dropped=0.
- Saturation and simultaneous hits (CNT_W=3, WINDOW=16):
  - Stimulus: hit=2'b11 every cycle.
  - Required: rpt_cnt101=7 and rpt_cnt010=7.
- Enable gating:
  - Stimulus: en=0 for 20 cycles mid-window while hit toggles.
  - Required: no counts added and no close.
  - Required after en returns to 1: the window closes after the remaining enabled cycles, with totals matching only the enabled-cycle hits.

Source files
------------

// File: rtl/pattern_hit_window_counter_if.sv
// Report channel from the window counter to the next stage: a valid/ready handshake with two count fields.
interface pattern_hit_window_counter_if #(
    parameter int CNT_W = 8
);
    logic             rpt_valid;
    logic             rpt_ready;
    logic [CNT_W-1:0] rpt_cnt101;
    logic [CNT_W-1:0] rpt_cnt010;

    modport master (
        output rpt_valid,
        output rpt_cnt101,
        output rpt_cnt010,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid,
        input  rpt_cnt101,
        input  rpt_cnt010,
        output rpt_ready
    );
endinterface

// File: rtl/pattern_hit_window_counter.sv
// Counts "101"/"010" detector hits over windows of WINDOW enabled cycles; the report appears on the edge ending the close cycle.
// Backpressure: one report slot; a window that closes while the slot is held and not accepted is dropped and flagged sticky.
module pattern_hit_window_counter #(
    parameter int CNT_W  = 8,
    parameter int WINDOW = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         en,
    input  logic [1:0]                   hit,
    input  logic                         clr_drop,
    output logic                         dropped,
    pattern_hit_window_counter_if.master rpt
);
    localparam int                 WCNT_W    = $clog2(WINDOW);
    localparam logic [WCNT_W-1:0]  WCNT_LAST = WCNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t            state_q,   state_d;
    logic [WCNT_W-1:0] wcnt_q,    wcnt_d;
    logic [CNT_W-1:0]  c101_q,    c101_d;
    logic [CNT_W-1:0]  c010_q,    c010_d;
    logic [CNT_W-1:0]  rpt101_q,  rpt101_d;
    logic [CNT_W-1:0]  rpt010_q,  rpt010_d;
    logic              dropped_q, dropped_d;

    logic              close;
    logic              accept;
    logic              drop;
    logic [CNT_W-1:0]  fin101;
    logic [CNT_W-1:0]  fin010;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
        return (inc && (c != CNT_MAX)) ? c + CNT_W'(1) : c;
    endfunction

    // Final counts include this cycle's hits so the close cycle is never lost.
    always_comb begin
        close  = en && (wcnt_q == WCNT_LAST);
        accept = (state_q == PENDING) && rpt.rpt_ready;
        fin101 = sat_inc(c101_q, hit[1]);
        fin010 = sat_inc(c010_q, hit[0]);
    end

    always_comb begin
        wcnt_d = wcnt_q;
        c101_d = c101_q;
        c010_d = c010_q;
        if (en) begin
            if (close) begin
                wcnt_d = '0;
                c101_d = '0;
                c010_d = '0;
            end else begin
                wcnt_d = wcnt_q + WCNT_W'(1);
                c101_d = fin101;
                c010_d = fin010;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rpt101_d = rpt101_q;
        rpt010_d = rpt010_q;
        drop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (close) begin
                    state_d  = PENDING;
                    rpt101_d = fin101;
                    rpt010_d = fin010;
                end
            end
            PENDING: begin
                if (close) begin
                    if (accept) begin
                        rpt101_d = fin101;
                        rpt010_d = fin010;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A drop in the same cycle as a clear must survive.
    always_comb begin
        dropped_d = dropped_q;
        if (clr_drop) begin
            dropped_d = 1'b0;
        end
        if (drop) begin
            dropped_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            c101_q    <= '0;
            c010_q    <= '0;
            rpt101_q  <= '0;
            rpt010_q  <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            c101_q    <= c101_d;
            c010_q    <= c010_d;
            rpt101_q  <= rpt101_d;
            rpt010_q  <= rpt010_d;
            dropped_q <= dropped_d;
        end
    end

    assign rpt.rpt_valid  = (state_q == PENDING);
    assign rpt.rpt_cnt101 = rpt101_q;
    assign rpt.rpt_cnt010 = rpt010_q;
    assign dropped        = dropped_q;
endmodule

// File: tb/tb_pattern_hit_window_counter.sv
// Drives an 8-bit and a 3-bit counter instance with identical stimulus and checks both against a window-level model.
module tb_pattern_hit_window_counter;
    localparam int WINDOW = 16;
    localparam int MAX_A  = 255;
    localparam int MAX_B  = 7;

    logic       clock    = 1'b0;
    logic       reset_n  = 1'b1;
    logic       en       = 1'b0;
    logic       clr_drop = 1'b0;
    logic [1:0] hit      = 2'b00;
    logic       dropped_a;
    logic       dropped_b;

    pattern_hit_window_counter_if #(.CNT_W(8)) rpt_a ();
    pattern_hit_window_counter_if #(.CNT_W(3)) rpt_b ();

    pattern_hit_window_counter #(.CNT_W(8), .WINDOW(WINDOW)) dut_a (
        .clock    (clock),
        .reset_n  (reset_n),
        .en       (en),
        .hit      (hit),
        .clr_drop (clr_drop),
        .dropped  (dropped_a),
        .rpt      (rpt_a)
    );

    pattern_hit_window_counter #(.CNT_W(3), .WINDOW(WINDOW)) dut_b (
        .clock    (clock),
        .reset_n  (reset_n),
        .en       (en),
        .hit      (hit),
        .clr_drop (clr_drop),
        .dropped  (dropped_b),
        .rpt      (rpt_b)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Model: raw (unbounded) hit totals per window; saturation is min(total, max) at compare time.
    int m_pos   = 0;
    int m_n101  = 0;
    int m_n010  = 0;
    int m_r101  = 0;
    int m_r010  = 0;
    bit m_valid = 1'b0;
    bit m_drop  = 1'b0;

    function automatic int sat(input int raw, input int maxv);
        return (raw > maxv) ? maxv : raw;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("valid_a", 32'(rpt_a.rpt_valid), 32'(m_valid));
        check("valid_b", 32'(rpt_b.rpt_valid), 32'(m_valid));
        check("dropped_a", 32'(dropped_a), 32'(m_drop));
        check("dropped_b", 32'(dropped_b), 32'(m_drop));
        if (m_valid) begin
            check("cnt101_a", 32'(rpt_a.rpt_cnt101), 32'(sat(m_r101, MAX_A)));
            check("cnt010_a", 32'(rpt_a.rpt_cnt010), 32'(sat(m_r010, MAX_A)));
            check("cnt101_b", 32'(rpt_b.rpt_cnt101), 32'(sat(m_r101, MAX_B)));
            check("cnt010_b", 32'(rpt_b.rpt_cnt010), 32'(sat(m_r010, MAX_B)));
        end
    endtask

    task automatic model_edge(input logic e, input logic [1:0] h, input logic rdy, input logic clr);
        bit closing;
        bit acc;
        bit lost;
        closing = e && (m_pos == WINDOW - 1);
        acc     = m_valid && rdy;
        lost    = 1'b0;
        if (e) begin
            m_n101 += int'(h[1]);
            m_n010 += int'(h[0]);
        end
        if (closing) begin
            if (!m_valid || acc) begin
                m_valid = 1'b1;
                m_r101  = m_n101;
                m_r010  = m_n010;
            end else begin
                lost = 1'b1;
            end
            m_pos  = 0;
            m_n101 = 0;
            m_n010 = 0;
        end else begin
            if (e) m_pos++;
            if (acc) m_valid = 1'b0;
        end
        if (clr) m_drop = 1'b0;
        if (lost) m_drop = 1'b1;
    endtask

    task automatic step(input logic e, input logic [1:0] h, input logic rdy, input logic clr);
        en              = e;
        hit             = h;
        rpt_a.rpt_ready = rdy;
        rpt_b.rpt_ready = rdy;
        clr_drop        = clr;
        @(posedge clock);
        model_edge(e, h, rdy, clr);
        #1;
        check_all();
    endtask

    // Asserted between edges so the clear must be asynchronous to show up before the next edge.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_valid_a", 32'(rpt_a.rpt_valid), 32'd0);
        check("rst_valid_b", 32'(rpt_b.rpt_valid), 32'd0);
        check("rst_101_a", 32'(rpt_a.rpt_cnt101), 32'd0);
        check("rst_010_a", 32'(rpt_a.rpt_cnt010), 32'd0);
        check("rst_101_b", 32'(rpt_b.rpt_cnt101), 32'd0);
        check("rst_010_b", 32'(rpt_b.rpt_cnt010), 32'd0);
        check("rst_drop_a", 32'(dropped_a), 32'd0);
        check("rst_drop_b", 32'(dropped_b), 32'd0);
        m_pos = 0; m_n101 = 0; m_n010 = 0; m_r101 = 0; m_r010 = 0;
        m_valid = 1'b0; m_drop = 1'b0;
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [1:0] h;
        int s101;
        int s010;
        rpt_a.rpt_ready = 1'b0;
        rpt_b.rpt_ready = 1'b0;

        do_reset();

        // Basic count: 3 x "101", 5 x "010", one "010" on the close cycle.
        for (int i = 0; i < WINDOW; i++) begin
            h = 2'b00;
            if (i == 2 || i == 5 || i == 9) h = 2'b10;
            if (i == 1 || i == 4 || i == 8 || i == 12 || i == 15) h = 2'b01;
            step(1'b1, h, 1'b0, 1'b0);
        end
        check("basic_valid", 32'(rpt_a.rpt_valid), 32'd1);
        check("basic_101", 32'(rpt_a.rpt_cnt101), 32'd3);
        check("basic_010", 32'(rpt_a.rpt_cnt010), 32'd5);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 2'b00, 1'b0, 1'b0);
            check("hold_101", 32'(rpt_a.rpt_cnt101), 32'd3);
            check("hold_010", 32'(rpt_a.rpt_cnt010), 32'd5);
        end

        // Back-pressure: the second close is discarded.
        for (int i = 0; i < 6; i++) begin
            h = 2'($urandom);
            step(1'b1, h, 1'b0, 1'b0);
        end
        check("bp_dropped", 32'(dropped_a), 32'd1);
        check("bp_keep_101", 32'(rpt_a.rpt_cnt101), 32'd3);
        check("bp_keep_010", 32'(rpt_a.rpt_cnt010), 32'd5);
        step(1'b0, 2'b11, 1'b0, 1'b1);
        check("clr_dropped", 32'(dropped_a), 32'd0);

        // Accept exactly on the close cycle: new report with no bubble.
        s101 = 0; s010 = 0;
        for (int i = 0; i < WINDOW; i++) begin
            h = 2'($urandom);
            s101 += int'(h[1]);
            s010 += int'(h[0]);
            step(1'b1, h, (i == WINDOW - 1), 1'b0);
        end
        check("aoc_valid", 32'(rpt_a.rpt_valid), 32'd1);
        check("aoc_101", 32'(rpt_a.rpt_cnt101), 32'(s101));
        check("aoc_010", 32'(rpt_a.rpt_cnt010), 32'(s010));
        check("aoc_dropped", 32'(dropped_a), 32'd0);

        // Saturation with simultaneous hits.
        step(1'b0, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < WINDOW; i++) step(1'b1, 2'b11, 1'b0, 1'b0);
        check("sat_101_b", 32'(rpt_b.rpt_cnt101), 32'd7);
        check("sat_010_b", 32'(rpt_b.rpt_cnt010), 32'd7);
        check("sat_101_a", 32'(rpt_a.rpt_cnt101), 32'd16);
        check("sat_010_a", 32'(rpt_a.rpt_cnt010), 32'd16);

        // Enable gating: hits while en=0 must not count and the window must not close.
        step(1'b0, 2'b00, 1'b1, 1'b0);
        s101 = 0; s010 = 0;
        for (int i = 0; i < 5; i++) begin
            h = 2'($urandom);
            s101 += int'(h[1]);
            s010 += int'(h[0]);
            step(1'b1, h, 1'b0, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            h = 2'(i);
            step(1'b0, h, 1'b0, 1'b0);
            check("gate_no_close", 32'(rpt_a.rpt_valid), 32'd0);
        end
        for (int i = 0; i < WINDOW - 5; i++) begin
            h = 2'($urandom);
            s101 += int'(h[1]);
            s010 += int'(h[0]);
            step(1'b1, h, 1'b0, 1'b0);
        end
        check("gate_valid", 32'(rpt_a.rpt_valid), 32'd1);
        check("gate_101", 32'(rpt_a.rpt_cnt101), 32'(s101));
        check("gate_010", 32'(rpt_a.rpt_cnt010), 32'(s010));

        // Reset mid-window with a pending report and the drop flag set.
        for (int i = 0; i < WINDOW; i++) step(1'b1, 2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 2'b10, 1'b0, 1'b0);
        check("pre_rst_valid", 32'(rpt_a.rpt_valid), 32'd1);
        check("pre_rst_drop", 32'(dropped_a), 32'd1);
        do_reset();
        for (int i = 0; i < WINDOW - 1; i++) step(1'b1, 2'b11, 1'b0, 1'b0);
        check("post_rst_early", 32'(rpt_a.rpt_valid), 32'd0);
        step(1'b1, 2'b11, 1'b0, 1'b0);
        check("post_rst_close", 32'(rpt_a.rpt_valid), 32'd1);
        check("post_rst_101", 32'(rpt_a.rpt_cnt101), 32'd16);

        // Random traffic with mixed enable, ready and clear.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(3) != 0), 2'($urandom), 1'($urandom), ($urandom_range(15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
